// File: rtl/aww_types_pkg.sv
// Shared arbiter types: which port currently owns the RAM.
package aww_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: status codes reported by the single-ported RAM.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data ports.
// Data wins by default; a streak counter guarantees a pending fetch a slot.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);
  import cpu_types_pkg::*;
  import aww_types_pkg::*;

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TCNT_W   = 8;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);
  localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT - 1);

  arb_state_t           state_q;
  logic [STREAK_W-1:0]  dstreak_q;
  logic [TCNT_W-1:0]    tcnt_q;
  logic                 err_q;

  ramstate_t rs;
  logic      dreq;
  logic      live;
  logic      icomp;
  logic      dcomp;
  logic      own_req;

  assign rs      = ramstate_t'(ramstate);
  assign dreq    = dREN | dWEN;
  // Reset kills an in-flight access in the same cycle it is asserted.
  assign live    = ~RST;
  assign icomp   = live & (state_q == IACC) & (rs == ACCESS);
  assign dcomp   = live & (state_q == DACC) & (rs == ACCESS);
  assign own_req = (state_q == IACC) ? iREN : dreq;

  assign iwait = iREN & ~icomp;
  assign dwait = dreq & ~dcomp;
  assign iload = ramload;
  assign dload = ramload;
  assign err   = err_q;

  // RAM command mux; a simultaneous dREN/dWEN is treated as a write.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (live) begin
      unique case (state_q)
        IACC: begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end
        DACC: begin
          ramREN   = dREN & ~dWEN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
        end
        default: ;
      endcase
    end
  end

  // Grant/complete sequencing, starvation streak and access watchdog.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      tcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!iREN) dstreak_q <= '0;
          if (dreq && !(iREN && (dstreak_q == STREAK_MAX))) begin
            state_q <= DACC;
            tcnt_q  <= '0;
          end else if (iREN) begin
            state_q   <= IACC;
            tcnt_q    <= '0;
            dstreak_q <= '0;
          end
        end
        IACC, DACC: begin
          if (!own_req) begin
            state_q <= IDLE;
          end else if (rs == ACCESS) begin
            state_q <= IDLE;
            if ((state_q == DACC) && iREN && (dstreak_q < STREAK_MAX))
              dstreak_q <= STREAK_W'(dstreak_q + 4'd1);
          end else if (rs == ERROR) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (tcnt_q == TCNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tcnt_q <= TCNT_W'(tcnt_q + 8'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model of port ownership.
module tb_mem_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned WW   = 32;
  localparam int          MAXS = 4;
  localparam int          TMO  = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [WW-1:0] dstore = '0;
  logic          iwait;
  logic [WW-1:0] iload;
  logic          dwait;
  logic [WW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [WW-1:0] ramstore;
  logic [WW-1:0] ramload = '0;
  logic [1:0]    ramstate = 2'd0;
  logic          err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .WORD_W(WW), .MAX_DSTREAK(MAXS), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .iload(iload), .dwait(dwait),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), data grants
  // served while fetch waited, cycles spent waiting on the RAM, error flag.
  int m_owner  = 0;
  int m_streak = 0;
  int m_wait   = 0;
  bit m_err    = 1'b0;
  bit exp_icomp = 1'b0;
  bit exp_dcomp = 1'b0;
  int seq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit dq;
    bit req;
    dq = dREN | dWEN;
    if (RST) begin
      m_owner = 0; m_streak = 0; m_wait = 0; m_err = 1'b0;
    end else if (m_owner == 0) begin
      if (!iREN) m_streak = 0;
      if (dq && !(iREN && m_streak == MAXS)) begin
        m_owner = 2; m_wait = 0;
      end else if (iREN) begin
        m_owner = 1; m_wait = 0; m_streak = 0;
      end
    end else begin
      req = (m_owner == 1) ? iREN : dq;
      if (!req) m_owner = 0;
      else if (ramstate == 2'd2) begin
        if (m_owner == 2 && iREN && m_streak < MAXS) m_streak++;
        m_owner = 0;
      end else if (ramstate == 2'd3) begin
        m_err = 1'b1; m_owner = 0;
      end else begin
        m_wait++;
        if (m_wait >= TMO) begin
          m_err = 1'b1; m_owner = 0;
        end
      end
    end
  endtask

  task automatic model_check();
    bit dq, live, done, er, ew;
    logic [31:0] ea, es;
    dq   = dREN | dWEN;
    live = !RST;
    done = live && (ramstate == 2'd2);
    exp_icomp = iREN && (m_owner == 1) && done;
    exp_dcomp = dq && (m_owner == 2) && done;
    er = live && (m_owner == 1 || (m_owner == 2 && dREN && !dWEN));
    ew = live && (m_owner == 2) && dWEN;
    ea = !live ? 32'h0 : (m_owner == 1) ? iaddr : (m_owner == 2) ? daddr : 32'h0;
    es = (live && m_owner == 2) ? dstore : 32'h0;
    check("iwait",    32'(iwait),  32'(iREN && !exp_icomp));
    check("dwait",    32'(dwait),  32'(dq && !exp_dcomp));
    check("ramREN",   32'(ramREN), 32'(er));
    check("ramWEN",   32'(ramWEN), 32'(ew));
    check("ramaddr",  ramaddr,     ea);
    check("ramstore", ramstore,    es);
    check("err",      32'(err),    32'(m_err));
    if (exp_icomp) check("iload", iload, ramload);
    if (exp_dcomp && dREN) check("dload", dload, ramload);
  endtask

  task automatic cyc(input bit rst, input bit ir, input logic [31:0] ia,
                     input bit dr, input bit dw, input logic [31:0] da,
                     input logic [31:0] ds, input logic [1:0] rs, input logic [31:0] ld);
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    RST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramstate = rs; ramload = ld;
    #1 model_check();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
  endtask

  initial begin
    bit ir, dr, dw;
    logic [31:0] ia, da, ds;
    logic [1:0] rs;
    int p;

    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);

    // Fetch only, two BUSY cycles then ACCESS.
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 32'h0);
    check("f_ramREN", 32'(ramREN), 32'd1);
    check("f_ramaddr", ramaddr, 32'h40);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 32'h0);
    check("f_iwait_busy", 32'(iwait), 32'd1);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 32'h8C010004);
    check("f_iwait_done", 32'(iwait), 32'd0);
    check("f_iload", iload, 32'h8C010004);
    idle();
    check("f_back_idle", 32'(ramREN), 32'd0);

    // Simultaneous requests: data first, then fetch after one bubble.
    cyc(1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 32'h100, 32'h0, 2'd0, 32'h0);
    cyc(1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 32'h55);
    check("s_dwait", 32'(dwait), 32'd0);
    check("s_iwait_held", 32'(iwait), 32'd1);
    check("s_daddr", ramaddr, 32'h100);
    check("s_dload", dload, 32'h55);
    cyc(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 32'h0);
    check("s_bubble_iwait", 32'(iwait), 32'd1);
    check("s_bubble_ren", 32'(ramREN), 32'd0);
    cyc(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 32'h66);
    check("s_iwait", 32'(iwait), 32'd0);
    check("s_iload", iload, 32'h66);
    idle();

    // Starvation guard: streaming writes against a pending fetch.
    seq.delete();
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 32'($urandom), 32'($urandom), 2'd2, 32'h0);
      if (iREN && !iwait) seq.push_back(1);
      if (dWEN && !dwait) seq.push_back(2);
    end
    check("sv_count", 32'(seq.size() >= 10), 32'd1);
    for (int k = 0; k < 10; k++)
      check("sv_order", 32'((k < seq.size()) ? seq[k] : 0), 32'(((k % 5) == 4) ? 1 : 2));
    idle();
    idle();

    // Write path.
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 2'd0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 2'd1, 32'h0);
    check("w_ramWEN", 32'(ramWEN), 32'd1);
    check("w_ramREN", 32'(ramREN), 32'd0);
    check("w_ramstore", ramstore, 32'hDEADBEEF);
    check("w_ramaddr", ramaddr, 32'h200);
    check("w_dwait_busy", 32'(dwait), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 2'd2, 32'h0);
    check("w_dwait_done", 32'(dwait), 32'd0);
    idle();
    check("w_idle_wen", 32'(ramWEN), 32'd0);

    // RAM ERROR during a data read: sticky err, request re-granted.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 2'd0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 2'd3, 32'h0);
    check("e_dwait_err", 32'(dwait), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 2'd0, 32'h0);
    check("e_err_set", 32'(err), 32'd1);
    check("e_dwait_after", 32'(dwait), 32'd1);
    check("e_idle_ren", 32'(ramREN), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 2'd1, 32'h0);
    check("e_regrant", 32'(ramREN), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 2'd2, 32'h77);
    check("e_done", 32'(dwait), 32'd0);
    check("e_err_sticky", 32'(err), 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    idle();
    check("e_err_cleared", 32'(err), 32'd0);

    // Watchdog: constant BUSY trips err after TMO access cycles.
    cyc(1'b0, 1'b1, 32'h90, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    for (int k = 1; k <= TMO; k++)
      cyc(1'b0, 1'b1, 32'h90, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 32'h0);
    check("t_err_not_yet", 32'(err), 32'd0);
    cyc(1'b0, 1'b1, 32'h90, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 32'h0);
    check("t_err_set", 32'(err), 32'd1);
    check("t_idle_ren", 32'(ramREN), 32'd0);
    check("t_iwait", 32'(iwait), 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    idle();

    // Reset pulse in the middle of a fetch.
    cyc(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    cyc(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 32'h0);
    check("r_ren_before", 32'(ramREN), 32'd1);
    cyc(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 32'h0);
    check("r_iwait_inrst", 32'(iwait), 32'd1);
    cyc(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 32'h0);
    check("r_ren_after", 32'(ramREN), 32'd0);
    check("r_addr_after", ramaddr, 32'h0);
    check("r_err_after", 32'(err), 32'd0);
    check("r_iwait_after", 32'(iwait), 32'd1);
    cyc(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 32'h0);
    check("r_restart", 32'(ramREN), 32'd1);
    check("r_restart_addr", ramaddr, 32'h44);
    cyc(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 32'h1234);
    check("r_done", 32'(iwait), 32'd0);
    idle();

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      ir = iREN; ia = iaddr; dr = dREN; dw = dWEN; da = daddr; ds = dstore;
      if (!ir) begin
        if ($urandom_range(99) < 30) begin ir = 1'b1; ia = $urandom; end
      end else if (exp_icomp || $urandom_range(99) < 3) ir = 1'b0;
      if (!(dr || dw)) begin
        if ($urandom_range(99) < 35) begin
          p  = int'($urandom_range(99));
          dw = (p < 45) || (p >= 97);
          dr = (p >= 45);
          da = $urandom; ds = $urandom;
        end
      end else if (exp_dcomp || $urandom_range(99) < 3) begin
        dr = 1'b0; dw = 1'b0;
      end
      p  = int'($urandom_range(99));
      rs = (p < 30) ? 2'd2 : (p < 85) ? 2'd1 : (p < 96) ? 2'd0 : 2'd3;
      cyc($urandom_range(99) < 1, ir, ia, dr, dw, da, ds, rs, 32'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
